// File: rtl/pattern_scan_ctrl.sv
// Bit-serial 4-bit pattern detector: scans each accepted byte MSB first, one bit per cycle,
// and reports per-word match count and first match position, plus a saturating running total.
module pattern_scan_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_count,
    output logic [2:0]       out_first,
    output logic             match_pulse,
    output logic [CNT_W-1:0] total_matches,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         sr_q, sr_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [2:0]         hist_q, hist_d;
    logic [1:0]         hist_len_q, hist_len_d;
    logic [3:0]         pat_q, pat_d;
    logic               ovl_q, ovl_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [2:0]         first_q, first_d;
    logic [CNT_W-1:0]   total_q, total_d;
    logic               match;
    logic               cur_bit;

    function automatic logic [CNT_W-1:0] sat_inc_total(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [1:0] sat_inc_len(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    assign cur_bit = sr_q[7];

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_idx_d  = bit_idx_q;
        hist_d     = hist_q;
        hist_len_d = hist_len_q;
        pat_d      = pat_q;
        ovl_d      = ovl_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        total_d    = total_q;
        match      = 1'b0;

        case (state_q)
            IDLE: begin
                // A config write in the accept cycle already governs the word being accepted.
                if (cfg_we) begin
                    pat_d      = cfg_pattern;
                    ovl_d      = cfg_overlap;
                    hist_len_d = 2'd0;
                end
                if (in_valid) begin
                    sr_d      = in_data;
                    bit_idx_d = 3'd0;
                    cnt_d     = 4'd0;
                    first_d   = 3'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                match     = ({hist_q, cur_bit} == pat_q) && (hist_len_q == 2'd3);
                sr_d      = {sr_q[6:0], 1'b0};
                hist_d    = {hist_q[1:0], cur_bit};
                // Non-overlapping mode restarts history so no bit is shared between matches.
                hist_len_d = (match && !ovl_q) ? 2'd0 : sat_inc_len(hist_len_q);
                if (match) begin
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd0) begin
                        first_d = bit_idx_q;
                    end
                    total_d = sat_inc_total(total_q);
                end
                bit_idx_d = bit_idx_q + 3'd1;
                if (bit_idx_q == 3'd7) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= 8'd0;
            bit_idx_q  <= 3'd0;
            hist_q     <= 3'd0;
            hist_len_q <= 2'd0;
            pat_q      <= 4'b1001;
            ovl_q      <= 1'b1;
            cnt_q      <= 4'd0;
            first_q    <= 3'd0;
            total_q    <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_idx_q  <= bit_idx_d;
            hist_q     <= hist_d;
            hist_len_q <= hist_len_d;
            pat_q      <= pat_d;
            ovl_q      <= ovl_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            total_q    <= total_d;
        end
    end

    // Handshake and status outputs are forced low while reset is held.
    assign in_ready      = (state_q == IDLE) && !rst;
    assign out_valid     = (state_q == REPORT) && !rst;
    assign busy          = (state_q != IDLE) && !rst;
    assign match_pulse   = match && !rst;
    assign out_count     = cnt_q;
    assign out_first     = first_q;
    assign total_matches = total_q;

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the running match counter total_matches.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cfg_we  input  1  configuration write strobe.
REQ-005 cfg_pattern  input  4  detect pattern; bit[3] is the oldest bit, bit[0] the newest.
REQ-006 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-007 in_valid  input  1  input word valid.
REQ-008 in_ready  output  1  block can accept a word.
REQ-009 in_data  input  8  word to scan, MSB first.
REQ-010 out_valid  output  1  per-word result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_count  output  4  number of matches completed within the word, 0..8.
REQ-013 out_first  output  3  bit index of the first match end (0 = in_data[7]); 0 when out_count=0.
REQ-014 match_pulse  output  1  Mealy pulse, high in the SHIFT cycle whose bit completes a match.
REQ-015 total_matches  output  CNT_W  running match count, saturating.
REQ-016 busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 FSM states: IDLE, SHIFT, REPORT. in_ready SHALL equal (state==IDLE).
REQ-018 IDLE with in_valid=1: latch in_data into the shift register, clear bit_idx to 0 and the per-word count, then go to SHIFT.
REQ-019 SHIFT: process one bit per cycle, MSB first. Cycle k (k = 0..7) processes in_data[7-k]. After k=7, go to REPORT.
REQ-020 Detector: hist is a 3-bit register of previous bits; hist_len saturates at 3. A match occurs when {hist, bit} == pattern and hist_len == 3.
REQ-021 On every processed bit: hist <= {hist[1:0], bit}; hist_len increments, saturating at 3. hist and hist_len persist across word boundaries.
REQ-022 On a match with overlap=0: hist_len SHALL be cleared to 0 in place of the increment.
REQ-023 On a match:
- match_pulse is high in that cycle.
- out_count increments.
- If this is the first match of the word, out_first <= k.
- total_matches increments, saturating at all-ones.
REQ-024 REPORT: out_valid=1. out_count and out_first are held stable until out_ready=1. On the handshake, go to IDLE; the next word can be accepted no earlier than the following cycle.
REQ-025 Latency: a word accepted at edge T gives out_valid=1 from the cycle after edge T+8. Throughput is at most one word per 10 cycles with out_ready tied high.
REQ-026 cfg_we is honoured only in IDLE. It loads the pattern and overlap setting and clears hist_len to 0. cfg_we in SHIFT or REPORT SHALL be ignored.
REQ-027 cfg_we and in_valid in the same IDLE cycle: the new configuration and the cleared history apply to that word.
REQ-028 total_matches is cleared only by rst.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL be set as follows:
- state = IDLE; pattern = 4'b1001; overlap = 1.
- hist = 0, hist_len = 0.
- out_count = 0, out_first = 0, total_matches = 0.
REQ-030 Output values with rst asserted: in_ready=0, out_valid=0, match_pulse=0, busy=0. in_ready=1 in the first cycle after rst deasserts.
REQ-031 rst asserted in any state SHALL abort the operation in progress; no result is presented for the aborted word.

Verification
REQ-032 Post-reset, word 8'b1001_0000 -> match_pulse at k=3; out_count=1, out_first=3, total_matches=1.
REQ-033 Overlap test, word 8'b1001_0010:
- cfg_overlap=1 -> out_count=2, out_first=3.
- After reset, cfg_overlap=0 -> out_count=1.
REQ-034 Cross-word match, words 8'b0000_0100 then 8'b1000_0000 -> counts 0 then 1; second word gives out_first=0, total_matches=1.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in REPORT -> out_valid, out_count and out_first stable; in_ready=0 and cfg_we pulses ignored. Then out_ready=1 -> in_ready=1 the next cycle.
REQ-036 History clear on configuration: word 8'b0000_0100, then cfg_we (pattern 4'b1001) in IDLE, then word 8'b1000_0000 -> second out_count=0.
REQ-037 Reset mid-operation: rst during SHIFT k=4 -> next cycle state IDLE, out_valid=0, total_matches=0, pattern=4'b1001.
